// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - parametrised pipeline stall/flush/redirect controller with perf counters
module pipe_ctrl #(
  parameter int NSTAGE = 5,
  parameter int RDEPTH = 1,
  parameter int PC_W   = 64,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSTAGE-1:0]     stall_req,
  input  logic                  redirect,
  input  logic [PC_W-1:0]       redirect_target,
  output logic [2*NSTAGE-1:0]   ctrl,
  output logic                  pc_redir_valid,
  output logic [PC_W-1:0]       pc_redir_target,
  input  logic                  cnt_clear,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      redir_cnt
);

  localparam int KW = $clog2(NSTAGE);

  localparam logic [1:0] C_STREAM = 2'b00;
  localparam logic [1:0] C_FLUSH  = 2'b01;
  localparam logic [1:0] C_KEEP   = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pend_target;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_redir_cnt;

  logic [KW-1:0]     w_k;
  logic              w_back_stall;
  logic              w_fetch_busy;
  logic              w_any_stall;
  logic              w_apply;
  logic              w_accept;

  // Locate the highest stalled back-end register; index 0 (fetch) is handled separately
  always_comb begin
    w_k          = '0;
    w_back_stall = 1'b0;
    for (int i = 1; i < NSTAGE; i++) begin
      if (stall_req[i]) begin
        w_k          = KW'(i);
        w_back_stall = 1'b1;
      end
    end
  end

  assign w_any_stall  = |stall_req;
  assign w_fetch_busy = stall_req[0] & ~w_back_stall;
  // A redirect is applied only when the whole pipe is free to move
  assign w_apply      = ~w_any_stall & (redirect | (r_state == ST_PEND));
  // Back-end stalls make the source hold its redirect, so it is not taken then
  assign w_accept     = redirect & ~w_back_stall;

  // Per-register write codes and PC redirect, priority back-end stall > fetch busy > redirect
  always_comb begin
    ctrl            = '0;
    pc_redir_valid  = 1'b0;
    pc_redir_target = '0;
    if (w_back_stall) begin
      for (int j = 0; j < NSTAGE; j++) begin
        if (j < int'(w_k)) begin
          ctrl[2*j +: 2] = C_KEEP;
        end else if (j == int'(w_k)) begin
          ctrl[2*j +: 2] = C_FLUSH;
        end else begin
          ctrl[2*j +: 2] = C_STREAM;
        end
      end
    end else if (w_fetch_busy) begin
      ctrl[1:0] = C_KEEP;
      ctrl[3:2] = C_FLUSH;
      if (redirect) begin
        for (int j = 1; j <= RDEPTH; j++) begin
          ctrl[2*j +: 2] = C_FLUSH;
        end
      end
    end else if (w_apply) begin
      pc_redir_valid  = 1'b1;
      pc_redir_target = redirect ? redirect_target : r_pend_target;
      ctrl[1:0]       = C_STREAM;
      // In PEND this also squashes the wrong-path instruction fetch just delivered
      for (int j = 1; j <= RDEPTH; j++) begin
        ctrl[2*j +: 2] = C_FLUSH;
      end
    end
  end

  // Pending-redirect FSM: park a redirect while fetch is busy, release when nothing stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pend_target <= '0;
    end else if (w_fetch_busy && redirect) begin
      r_state       <= ST_PEND;
      r_pend_target <= redirect_target;
    end else if (!w_any_stall) begin
      r_state       <= ST_IDLE;
    end
  end

  // Saturating count of cycles where the PC register was held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (cnt_clear) begin
      r_stall_cnt <= '0;
    end else if (w_any_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Saturating count of accepted redirects; replaying a pending one is not recounted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_redir_cnt <= '0;
    end else if (cnt_clear) begin
      r_redir_cnt <= '0;
    end else if (w_accept && (r_redir_cnt != {CNT_W{1'b1}})) begin
      r_redir_cnt <= r_redir_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign redir_cnt = r_redir_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - table-driven scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  stall_req;
  logic        redirect;
  logic [63:0] redirect_target;
  logic        cnt_clear;

  logic [9:0]  ctrl0, ctrl1;
  logic        v0, v1;
  logic [63:0] t0, t1;
  logic [31:0] sc0, rc0;
  logic [3:0]  sc1, rc1;

  int tests;
  int fails;

  // u0: default params; u1: deeper squash, 4-bit counters
  pipe_ctrl #(.NSTAGE(5), .RDEPTH(1), .PC_W(64), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .stall_req(stall_req), .redirect(redirect),
    .redirect_target(redirect_target), .ctrl(ctrl0), .pc_redir_valid(v0),
    .pc_redir_target(t0), .cnt_clear(cnt_clear), .stall_cnt(sc0), .redir_cnt(rc0)
  );

  pipe_ctrl #(.NSTAGE(5), .RDEPTH(3), .PC_W(64), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .stall_req(stall_req), .redirect(redirect),
    .redirect_target(redirect_target), .ctrl(ctrl1), .pc_redir_valid(v1),
    .pc_redir_target(t1), .cnt_clear(cnt_clear), .stall_cnt(sc1), .redir_cnt(rc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  sr;
    logic        rd;
    logic [63:0] tgt;
    logic [9:0]  c0;
    logic [9:0]  c1;
    logic        v;
    logic [63:0] t;
    logic [31:0] sc;
    logic [31:0] rc;
  } vec_t;

  vec_t vecs[19];
  vec_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] sat4(input logic [31:0] x);
    return (x > 32'd15) ? 4'hF : x[3:0];
  endfunction

  // Drive one vector and queue its expectations; compare once outputs settle
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    stall_req       = v.sr;
    redirect        = v.rd;
    redirect_target = v.tgt;
    cnt_clear       = 1'b0;
    sb_q.push_back(v);
    #2;
    e = sb_q.pop_front();
    chk($sformatf("v%0d ctrl0", idx), 64'(ctrl0), 64'(e.c0));
    chk($sformatf("v%0d ctrl1", idx), 64'(ctrl1), 64'(e.c1));
    chk($sformatf("v%0d valid0", idx), 64'(v0), 64'(e.v));
    chk($sformatf("v%0d valid1", idx), 64'(v1), 64'(e.v));
    chk($sformatf("v%0d tgt0", idx), t0, e.t);
    chk($sformatf("v%0d tgt1", idx), t1, e.t);
    chk($sformatf("v%0d stall_cnt0", idx), 64'(sc0), 64'(e.sc));
    chk($sformatf("v%0d redir_cnt0", idx), 64'(rc0), 64'(e.rc));
    chk($sformatf("v%0d stall_cnt1", idx), 64'(sc1), 64'(sat4(e.sc)));
    chk($sformatf("v%0d redir_cnt1", idx), 64'(rc1), 64'(sat4(e.rc)));
  endtask

  localparam logic [9:0] C_K4   = 10'b01_11_11_11_11;
  localparam logic [9:0] C_K3   = 10'b00_01_11_11_11;
  localparam logic [9:0] C_R1   = 10'b00_00_00_01_00;
  localparam logic [9:0] C_R3   = 10'b00_01_01_01_00;
  localparam logic [9:0] C_F1   = 10'b00_00_00_01_11;
  localparam logic [9:0] C_F3   = 10'b00_01_01_01_11;

  initial begin
    tests = 0;
    fails = 0;
    // sr, rd, tgt, ctrl(R1), ctrl(R3), valid, target, stall_cnt, redir_cnt (counts before this cycle)
    vecs[0]  = '{5'b10000, 1'b0, 64'h0,         C_K4,  C_K4,  1'b0, 64'h0,         32'd0,  32'd0};
    vecs[1]  = '{5'b01010, 1'b0, 64'h0,         C_K3,  C_K3,  1'b0, 64'h0,         32'd1,  32'd0};
    vecs[2]  = '{5'b00000, 1'b1, 64'h8000_0040, C_R1,  C_R3,  1'b1, 64'h8000_0040, 32'd2,  32'd0};
    vecs[3]  = '{5'b00000, 1'b0, 64'h0,         10'h0, 10'h0, 1'b0, 64'h0,         32'd2,  32'd1};
    vecs[4]  = '{5'b00001, 1'b1, 64'h100,       C_F1,  C_F3,  1'b0, 64'h0,         32'd2,  32'd1};
    vecs[5]  = '{5'b00001, 1'b0, 64'h0,         C_F1,  C_F1,  1'b0, 64'h0,         32'd3,  32'd2};
    vecs[6]  = '{5'b00001, 1'b0, 64'h0,         C_F1,  C_F1,  1'b0, 64'h0,         32'd4,  32'd2};
    vecs[7]  = '{5'b00000, 1'b0, 64'h0,         C_R1,  C_R3,  1'b1, 64'h100,       32'd5,  32'd2};
    vecs[8]  = '{5'b00000, 1'b0, 64'h0,         10'h0, 10'h0, 1'b0, 64'h0,         32'd5,  32'd2};
    vecs[9]  = '{5'b00001, 1'b1, 64'h200,       C_F1,  C_F3,  1'b0, 64'h0,         32'd5,  32'd2};
    vecs[10] = '{5'b01000, 1'b1, 64'h300,       C_K3,  C_K3,  1'b0, 64'h0,         32'd6,  32'd3};
    vecs[11] = '{5'b01000, 1'b0, 64'h0,         C_K3,  C_K3,  1'b0, 64'h0,         32'd7,  32'd3};
    vecs[12] = '{5'b00000, 1'b0, 64'h0,         C_R1,  C_R3,  1'b1, 64'h200,       32'd8,  32'd3};
    vecs[13] = '{5'b00001, 1'b1, 64'h400,       C_F1,  C_F3,  1'b0, 64'h0,         32'd8,  32'd3};
    vecs[14] = '{5'b00001, 1'b1, 64'h500,       C_F1,  C_F3,  1'b0, 64'h0,         32'd9,  32'd4};
    vecs[15] = '{5'b00000, 1'b1, 64'h600,       C_R1,  C_R3,  1'b1, 64'h600,       32'd10, 32'd5};
    vecs[16] = '{5'b00000, 1'b0, 64'h0,         10'h0, 10'h0, 1'b0, 64'h0,         32'd10, 32'd6};
    vecs[17] = '{5'b10001, 1'b1, 64'h700,       C_K4,  C_K4,  1'b0, 64'h0,         32'd10, 32'd6};
    vecs[18] = '{5'b00000, 1'b0, 64'h0,         10'h0, 10'h0, 1'b0, 64'h0,         32'd11, 32'd6};

    reset           = 1'b1;
    stall_req       = '0;
    redirect        = 1'b0;
    redirect_target = '0;
    cnt_clear       = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("reset ctrl0", 64'(ctrl0), 64'h0);
    chk("reset valid0", 64'(v0), 64'h0);
    chk("reset tgt0", t0, 64'h0);
    chk("reset stall_cnt0", 64'(sc0), 64'h0);
    chk("reset redir_cnt0", 64'(rc0), 64'h0);
    chk("reset stall_cnt1", 64'(sc1), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step(vecs[i], i);
    end

    // Saturation: 20 fetch-busy cycles on top of 11 already counted
    repeat (20) begin
      @(negedge clk);
      stall_req = 5'b00001;
      redirect  = 1'b0;
    end
    @(negedge clk);
    cnt_clear = 1'b1;
    #2;
    chk("sat stall_cnt0", 64'(sc0), 64'd31);
    chk("sat stall_cnt1", 64'(sc1), 64'd15);
    chk("sat redir_cnt1", 64'(rc1), 64'd6);
    @(negedge clk);
    cnt_clear = 1'b0;
    stall_req = '0;
    #2;
    chk("clear stall_cnt0", 64'(sc0), 64'd0);
    chk("clear stall_cnt1", 64'(sc1), 64'd0);
    chk("clear redir_cnt0", 64'(rc0), 64'd0);

    // Reset during PEND must drop the pending redirect
    @(negedge clk);
    stall_req       = 5'b00001;
    redirect        = 1'b1;
    redirect_target = 64'hABC;
    #2;
    chk("pend valid0", 64'(v0), 64'h0);
    @(negedge clk);
    stall_req = '0;
    redirect  = 1'b0;
    reset     = 1'b1;
    #2;
    chk("rst-pend valid0", 64'(v0), 64'h0);
    chk("rst-pend valid1", 64'(v1), 64'h0);
    chk("rst-pend redir_cnt0", 64'(rc0), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("post-rst valid0", 64'(v0), 64'h0);
    chk("post-rst ctrl1", 64'(ctrl1), 64'h0);
    chk("post-rst tgt1", t1, 64'h0);
    @(negedge clk);
    #2;
    chk("post-rst2 valid1", 64'(v1), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
